// File: rtl/drum_seq_pkg.sv
// Shared types and elaboration-time helpers for the drum step sequencer.
package drum_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_t;

  // Ceiling log2 for parameter derivation; clog2(1) = 0.
  function automatic int clog2(input longint unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 63; i++)
      if ((64'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Phase accumulator modulus: clock cycles per minute.
  function automatic longint unsigned den_f(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

  // One spare bit so acc + inc never wraps.
  function automatic int acc_w_f(input longint unsigned clk_hz);
    return clog2(den_f(clk_hz)) + 1;
  endfunction

endpackage

// File: rtl/bpm_tick_gen.sv
// Exact-rate step tick: adds inc every enabled cycle and wraps at DEN.
module bpm_tick_gen
  import drum_seq_pkg::*;
#(
  parameter longint unsigned DEN   = den_f(100),
  parameter int              ACC_W = acc_w_f(100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  localparam logic [ACC_W:0] DEN_V = (ACC_W+1)'(DEN);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Full-width sum so the compare never sees a wrapped value.
  assign sum  = {1'b0, acc} + {1'b0, inc};
  assign tick = en && (sum >= DEN_V);

  // Phase register; clr (start/stop) restarts the phase from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     acc <= '0;
    else if (clr)  acc <= '0;
    else if (en)   acc <= tick ? ACC_W'(sum - DEN_V) : sum[ACC_W-1:0];
  end

endmodule

// File: rtl/drum_step_sequencer.sv
// N-channel, S-step pattern sequencer with double-buffered pattern banks.
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          NUM_STEPS      = 8,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int          STEPS_PER_BEAT = 2,
  parameter int          BPM_W          = 8,
  localparam int         STEP_W         = clog2(NUM_STEPS),
  localparam int         CH_W           = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 pat_we,
  input  logic [CH_W-1:0]      pat_ch,
  input  logic [NUM_STEPS-1:0] pat_data,
  input  logic                 bpm_we,
  input  logic [BPM_W-1:0]     bpm_in,
  output logic [NUM_CH-1:0]    trig,
  output logic [STEP_W-1:0]    step,
  output logic                 playing,
  output logic                 bar_start,
  output logic [BPM_W-1:0]     bpm_out
);

  localparam longint unsigned DEN   = den_f(64'(CLK_HZ));
  localparam int              ACC_W = acc_w_f(64'(CLK_HZ));

  state_t state, state_nxt;
  logic [NUM_CH-1:0][NUM_STEPS-1:0] shadow, active;
  logic [ACC_W-1:0]  inc;
  logic [STEP_W-1:0] step_nxt;
  logic [NUM_CH-1:0] col_nxt, col_act0, col_shd0;
  logic tick, enter, leave, wrap, ch_ok;

  assign inc      = ACC_W'(bpm_out) * ACC_W'(STEPS_PER_BEAT);
  assign step_nxt = (step == STEP_W'(NUM_STEPS-1)) ? '0 : step + 1'b1;
  assign wrap     = tick && (step_nxt == '0);
  assign ch_ok    = int'(pat_ch) < NUM_CH;

  // Per-channel hit bits for the upcoming step and for step 0 of either bank.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_col
    assign col_nxt[c]  = active[c][step_nxt];
    assign col_act0[c] = active[c][0];
    assign col_shd0[c] = shadow[c][0];
  end

  bpm_tick_gen #(.DEN(DEN), .ACC_W(ACC_W)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (enter || leave),
    .en    (state == ST_PLAY && !stop),
    .inc   (inc),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: stop dominates start; start in PLAY is ignored.
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    leave     = 1'b0;
    case (state)
      ST_IDLE: if (start && !stop) begin state_nxt = ST_PLAY; enter = 1'b1; end
      ST_PLAY: if (stop)           begin state_nxt = ST_IDLE; leave = 1'b1; end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Step counter and registered trigger/bar pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step      <= '0;
      trig      <= '0;
      bar_start <= 1'b0;
      playing   <= 1'b0;
    end else begin
      trig      <= '0;
      bar_start <= 1'b0;
      playing   <= (state_nxt == ST_PLAY);
      if (leave) begin
        step <= '0;
      end else if (enter) begin
        step      <= '0;
        trig      <= col_act0;
        bar_start <= 1'b1;
      end else if (tick) begin
        step      <= step_nxt;
        trig      <= wrap ? col_shd0 : col_nxt;
        bar_start <= wrap;
      end
    end
  end

  // Pattern banks: edits go live immediately in IDLE, at the next bar in PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (wrap) active <= shadow;
      if (pat_we && ch_ok) begin
        shadow[pat_ch] <= pat_data;
        if (state == ST_IDLE) active[pat_ch] <= pat_data;
      end
    end
  end

  // Tempo register; takes effect on the accumulator the cycle after the write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       bpm_out <= '0;
    else if (bpm_we) bpm_out <= bpm_in;
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench: NUM_CH=3, NUM_STEPS=16, CLK_HZ=100, STEPS_PER_BEAT=1 (DEN=6000).
// Expected trig/bar_start events are queued with their cycle and popped by a monitor.
module tb_drum_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, pat_we, bpm_we;
  logic [1:0]  pat_ch;
  logic [15:0] pat_data;
  logic [7:0]  bpm_in, bpm_out;
  logic [2:0]  trig;
  logic [3:0]  step;
  logic        playing, bar_start;

  typedef struct {
    int         cyc;
    logic [2:0] trig;
    logic [3:0] step;
    logic       bar;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  drum_step_sequencer #(
    .NUM_CH(3), .NUM_STEPS(16), .CLK_HZ(100), .STEPS_PER_BEAT(1), .BPM_W(8)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .stop(stop),
    .pat_we(pat_we), .pat_ch(pat_ch), .pat_data(pat_data),
    .bpm_we(bpm_we), .bpm_in(bpm_in),
    .trig(trig), .step(step), .playing(playing),
    .bar_start(bar_start), .bpm_out(bpm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input logic [2:0] t, input logic [3:0] s, input logic b);
    ev_t e;
    e.cyc = c; e.trig = t; e.step = s; e.bar = b;
    q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) adv();
  endtask

  task automatic wr_pat(input int ch, input logic [15:0] d);
    pat_we = 1'b1; pat_ch = 2'(ch); pat_data = d;
    adv();
    pat_we = 1'b0;
  endtask

  task automatic wr_bpm(input logic [7:0] b);
    bpm_we = 1'b1; bpm_in = b;
    adv();
    bpm_we = 1'b0;
  endtask

  // Scoreboard monitor: every trig or bar_start pulse must match the queue head.
  always @(negedge clk) begin
    if (!rst && (trig !== 3'b0 || bar_start !== 1'b0)) begin
      if (q.size() == 0) begin
        check("ev_unexpected", {28'b0, trig, bar_start}, 32'd0);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("ev_cycle", cyc, e.cyc);
        check("ev_trig", 32'(trig), 32'(e.trig));
        check("ev_step", 32'(step), 32'(e.step));
        check("ev_bar", 32'(bar_start), 32'(e.bar));
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1; start = 0; stop = 0; pat_we = 0; bpm_we = 0;
    pat_ch = '0; pat_data = '0; bpm_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", 32'(trig), 0);
    check("rst_step", 32'(step), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_bar", 32'(bar_start), 0);
    check("rst_bpm", 32'(bpm_out), 0);
    rst = 1'b0;
    adv();

    // Run A: bpm 60 -> 100 cycles per step; out-of-range channel write ignored.
    wr_pat(0, 16'h0005);
    wr_pat(1, 16'h0000);
    wr_pat(2, 16'h0000);
    wr_pat(3, 16'hFFFF);
    wr_bpm(8'd60);
    check("a_bpm_out", 32'(bpm_out), 60);
    check("a_idle", 32'(playing), 0);
    t = cyc;
    push(t + 1, 3'b001, 0, 1);
    push(t + 201, 3'b001, 2, 0);
    push(t + 1601, 3'b001, 0, 1);
    push(t + 1801, 3'b001, 2, 0);
    start = 1'b1; adv(); start = 1'b0;
    check("a_playing", 32'(playing), 1);
    check("a_step0", 32'(step), 0);
    go_to(t + 100);  check("a_step_hold", 32'(step), 0);
    go_to(t + 101);  check("a_step1", 32'(step), 1);
    go_to(t + 1501); check("a_step15", 32'(step), 15);
    go_to(t + 1810);
    stop = 1'b1; adv(); stop = 1'b0;
    check("a_stop_step", 32'(step), 0);
    check("a_stop_playing", 32'(playing), 0);
    check("a_stop_trig", 32'(trig), 0);

    // Run B: mid-bar edits land in the shadow bank only, including on a tick cycle.
    wr_pat(0, 16'h0000);
    wr_pat(1, 16'hFFFF);
    wr_bpm(8'd120);
    t = cyc;
    for (int n = 0; n < 16; n++) push(t + 1 + 50 * n, 3'b010, 4'(n), n == 0);
    push(t + 801, 3'b010, 0, 1);
    push(t + 1601, 3'b110, 0, 1);
    push(t + 1651, 3'b100, 1, 0);
    start = 1'b1; adv(); start = 1'b0;
    go_to(t + 161); wr_pat(1, 16'h0001);
    go_to(t + 850); wr_pat(2, 16'h0003);
    go_to(t + 1660);
    stop = 1'b1; adv(); stop = 1'b0;

    // Run C: tempo 0 freezes the step, phase resumes continuously at 120.
    wr_pat(0, 16'hFFFF);
    t = cyc;
    push(t + 1, 3'b111, 0, 1);
    push(t + 51, 3'b101, 1, 0);
    push(t + 101, 3'b001, 2, 0);
    push(t + 151, 3'b001, 3, 0);
    push(t + 402, 3'b001, 4, 0);
    push(t + 452, 3'b001, 5, 0);
    start = 1'b1; adv(); start = 1'b0;
    go_to(t + 170); wr_bpm(8'd0);
    check("c_bpm_zero", 32'(bpm_out), 0);
    go_to(t + 371);
    check("c_step_hold", 32'(step), 3);
    check("c_still_playing", 32'(playing), 1);
    wr_bpm(8'd120);
    go_to(t + 460);
    stop = 1'b1; adv(); stop = 1'b0;
    check("c_stop_step", 32'(step), 0);
    check("c_stop_trig", 32'(trig), 0);
    check("c_stop_playing", 32'(playing), 0);
    go_to(t + 470);
    start = 1'b1; stop = 1'b1; adv(); start = 1'b0; stop = 1'b0;
    check("c_start_stop", 32'(playing), 0);

    // Restart from step 0, then async reset while a trig is showing.
    t = cyc;
    push(t + 1, 3'b111, 0, 1);
    start = 1'b1; adv(); start = 1'b0;
    go_to(t + 51);
    check("r_trig_before", 32'(trig), 32'b101);
    rst = 1'b1;
    #1;
    check("r_trig", 32'(trig), 0);
    check("r_step", 32'(step), 0);
    check("r_playing", 32'(playing), 0);
    check("r_bpm", 32'(bpm_out), 0);
    adv(); adv();
    rst = 1'b0;
    adv();

    // Patterns were cleared: only bar_start pulses, never a trig.
    wr_bpm(8'd120);
    t = cyc;
    push(t + 1, 3'b000, 0, 1);
    push(t + 801, 3'b000, 0, 1);
    start = 1'b1; adv(); start = 1'b0;
    go_to(t + 851);
    check("p_step1", 32'(step), 1);
    check("p_playing", 32'(playing), 1);
    go_to(t + 860);
    stop = 1'b1; adv(); stop = 1'b0;
    adv();
    check("queue_empty", 32'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
